// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU writeback stage: default result width,
// register index width, {N,Z,P} condition-code bit positions and the
// condition-code reset value, plus a small flag-validity helper.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int REG_IDX_W  = 3;

  // Bit positions inside the 3-bit condition code {N,Z,P}.
  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;

  // Condition codes come out of reset as "zero".
  localparam logic [2:0] NZP_RESET = 3'b010;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // A legal flag vector from the ALU has exactly one of N/Z/P set.
  function automatic logic is_onehot3(input logic [2:0] flags);
    return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Register-based FIFO holding pending ALU results (value + destination).
// Head entry is read straight out of registered storage, so there is no
// combinational path from wdata to rdata.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   push, pop     enqueue wdata / dequeue head (ignored when full / empty)
//   flush         synchronous discard of all entries; wins over push/pop
//   wdata, rdata  entry written on push / oldest entry
//   count         number of stored entries (0..DEPTH)
//   full, empty   occupancy status
// -----------------------------------------------------------------------------
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);

  // Flush takes priority, so neither a push nor a pop is honoured with it.
  assign push_ok = push && !full  && !flush;
  assign pop_ok  = pop  && !empty && !flush;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - CW'(1);
    end
  end

  // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= wdata;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  assign rdata = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
// Buffers ALU results for the register file and maintains the {N,Z,P}
// condition-code register used for branch resolution.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   in_valid/in_ready            result handshake from the ALU
//   in_result, in_dest           result value and destination register
//   in_zero/positive/negative    ALU flags
//   in_setcc                     result updates the condition codes
//   flush                        discard all buffered results
//   wb_valid/wb_ready            handshake towards the register file
//   wb_data, wb_dest             oldest buffered result
//   nzp                          condition-code register {N,Z,P}
//   br_mask, br_taken            branch condition in / satisfied out
//   count                        number of buffered results
//   flag_err                     sticky: a setcc result had illegal flags
// -----------------------------------------------------------------------------
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_result,
  input  logic                   in_zero,
  input  logic                   in_positive,
  input  logic                   in_negative,
  input  logic [REG_IDX_W-1:0]   in_dest,
  input  logic                   in_setcc,
  input  logic                   flush,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [DW-1:0]          wb_data,
  output logic [REG_IDX_W-1:0]   wb_dest,
  output logic [2:0]             nzp,
  input  logic [2:0]             br_mask,
  output logic                   br_taken,
  output logic [$clog2(DEPTH):0] count,
  output logic                   flag_err
);

  localparam int EW = DW + REG_IDX_W;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [2:0]    flags;
  logic [2:0]    nzp_reg;
  logic [2:0]    nzp_next;
  logic          flag_err_reg;
  logic          flag_err_next;

  // Ready depends only on occupancy, never on wb_ready.
  assign in_ready = !fifo_full;
  assign wb_valid = !fifo_empty;

  // A push coinciding with flush is dropped, including its flag update.
  assign push = in_valid && in_ready && !flush;
  assign pop  = wb_valid && wb_ready;

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({in_dest, in_result}),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wb_dest = head[EW-1:DW];
  assign wb_data = head[DW-1:0];

  always_comb begin
    flags              = '0;
    flags[NZP_N]       = in_negative;
    flags[NZP_Z]       = in_zero;
    flags[NZP_P]       = in_positive;
    nzp_next           = nzp_reg;
    flag_err_next      = flag_err_reg;
    if (push && in_setcc) begin
      if (is_onehot3(flags)) begin
        nzp_next = flags;
      end else begin
        // Ambiguous flags: keep the last good condition codes.
        flag_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzp_reg      <= NZP_RESET;
      flag_err_reg <= 1'b0;
    end else begin
      nzp_reg      <= nzp_next;
      flag_err_reg <= flag_err_next;
    end
  end

  assign nzp      = nzp_reg;
  assign flag_err = flag_err_reg;
  assign br_taken = |(br_mask & nzp_reg);

endmodule
